// File: rtl/shifter_pkg.sv
// ----------------------------------------------------------------------------
// shifter_pkg
// Shared types for the multi-cycle shifter (seq_shifter) and its
// combinational step unit (shift_step).
//   shift_op_t : shift mode encoding, matches the 2-bit `op` port
//   state_t    : control FSM states
// ----------------------------------------------------------------------------
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// ----------------------------------------------------------------------------
// shift_step
// Combinational N-bit shift by k positions (0 <= k <= STEP) in one of the
// four shifter modes. Also returns the last bit shifted out (0 when k = 0).
// Ports:
//   word_i : word to shift
//   k_i    : number of positions for this step
//   op_i   : shift mode
//   sign_i : fill bit for SRA (sign of the originally latched operand)
//   word_o : shifted word
//   last_o : last bit that left the word
// ----------------------------------------------------------------------------
module shift_step
    import shifter_pkg::*;
#(
    parameter int N    = 4,
    parameter int STEP = 1,
    parameter int KW   = $clog2(STEP + 1)
) (
    input  logic [N-1:0]  word_i,
    input  logic [KW-1:0] k_i,
    input  shift_op_t     op_i,
    input  logic          sign_i,
    output logic [N-1:0]  word_o,
    output logic          last_o
);

    // Unrolled chain of STEP single-bit stages; stage i is active when i < k.
    always_comb begin
        logic [N-1:0] w;
        logic         lo;
        w  = word_i;
        lo = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(k_i)) begin
                case (op_i)
                    SHIFT_SLL: begin
                        lo = w[N-1];
                        w  = {w[N-2:0], 1'b0};
                    end
                    SHIFT_SRL: begin
                        lo = w[0];
                        w  = {1'b0, w[N-1:1]};
                    end
                    SHIFT_SRA: begin
                        lo = w[0];
                        w  = {sign_i, w[N-1:1]};
                    end
                    SHIFT_ROR: begin
                        lo = w[0];
                        w  = {w[0], w[N-1:1]};
                    end
                endcase
            end
        end
        word_o = w;
        last_o = lo;
    end

endmodule

// File: rtl/seq_shifter.sv
// ----------------------------------------------------------------------------
// seq_shifter
// Multi-cycle shifter (SLL, SRL, SRA, ROR) that moves at most STEP bit
// positions per clock. Driven through a start/busy/done handshake.
// Optional flags: define SEQ_SHIFTER_FLAGS_EN to compute `zero`/`carry`;
// otherwise both are tied to 0 and the carry logic is absent.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only while idle
//   a, b, op   : operand, shift amount, mode (00 SLL, 01 SRL, 10 SRA, 11 ROR)
//   c          : result, held until the next accepted start
//   busy       : from the cycle after acceptance through the done cycle
//   done       : one-cycle pulse when c is valid
//   zero       : c == 0, valid with done
//   carry      : last bit shifted out, valid with done
// ----------------------------------------------------------------------------
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int N    = 4,
    parameter int STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N-1:0]         a,
    input  logic [$clog2(N)-1:0] b,
    input  logic [1:0]           op,
    output logic [N-1:0]         c,
    output logic                 busy,
    output logic                 done,
    output logic                 zero,
    output logic                 carry
);

    // rem must hold N itself (saturated SLL/SRL/SRA for b >= N)
    localparam int RW = $clog2(N + 1);
    localparam int KW = $clog2(STEP + 1);

    state_t        state_q;
    logic [RW-1:0] rem_q;
    logic [N-1:0]  c_q;
    logic          busy_q;
    logic          done_q;

    logic [N-1:0]  work_q;
    shift_op_t     op_q;
    logic          sign_q;

    shift_op_t     op_w;
    logic [RW-1:0] eff_w;
    logic [RW-1:0] rem_d;
    logic [KW-1:0] k_w;
    logic [N-1:0]  step_word_w;
    logic          step_last_w;
    logic          fin_idle_w;
    logic          fin_shift_w;

    assign op_w = shift_op_t'(op);

    // Effective amount. b >= N is only reachable for non-power-of-two N:
    // a shift by N yields all-zero / all-sign, a rotate wraps to b - N.
    always_comb begin
        eff_w = RW'(b);
        if (int'(b) >= N) begin
            if (op_w == SHIFT_ROR) eff_w = RW'(int'(b) - N);
            else                   eff_w = RW'(N);
        end
    end

    always_comb begin
        if (int'(rem_q) >= STEP) k_w = KW'(STEP);
        else                     k_w = KW'(rem_q);
    end

    assign rem_d = rem_q - RW'(k_w);

    // Result becomes final either straight from IDLE (zero-length) or on
    // the SHIFT cycle that consumes the remaining count.
    assign fin_idle_w  = (state_q == ST_IDLE) && start && (eff_w == '0);
    assign fin_shift_w = (state_q == ST_SHIFT) && (rem_d == '0);

    shift_step #(
        .N    (N),
        .STEP (STEP),
        .KW   (KW)
    ) u_step (
        .word_i (work_q),
        .k_i    (k_w),
        .op_i   (op_q),
        .sign_i (sign_q),
        .word_o (step_word_w),
        .last_o (step_last_w)
    );

    // Working datapath; no reset needed, it is always loaded on acceptance.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && start) begin
            work_q <= a;
            op_q   <= op_w;
            sign_q <= a[N-1];
        end else if (state_q == ST_SHIFT) begin
            work_q <= step_word_w;
        end
    end

    // Control FSM with registered handshake outputs and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        rem_q  <= eff_w;
                        if (fin_idle_w) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            c_q     <= a;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    rem_q <= rem_d;
                    if (fin_shift_w) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        c_q     <= step_word_w;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign c    = c_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef SEQ_SHIFTER_FLAGS_EN
    logic zero_q;
    logic carry_q;
    logic carry_imm_w;

    // Zero-length result: only a rotate by exactly N has moved bits, and
    // the last one out of the LSB is then a[N-1].
    assign carry_imm_w = (op_w == SHIFT_ROR && b != '0) ? a[N-1] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (fin_idle_w) begin
            zero_q  <= (a == '0);
            carry_q <= carry_imm_w;
        end else if (fin_shift_w) begin
            zero_q  <= (step_word_w == '0);
            carry_q <= step_last_w;
        end
    end

    assign zero  = zero_q;
    assign carry = carry_q;
`else
    logic unused_step_last;
    assign unused_step_last = step_last_w;
    assign zero  = 1'b0;
    assign carry = 1'b0;
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// ----------------------------------------------------------------------------
// tb_seq_shifter
// Directed bench for seq_shifter over four configurations:
//   dut 0: N=4 STEP=1, dut 1: N=8 STEP=3, dut 2: N=8 STEP=2, dut 3: N=5 STEP=2
// ----------------------------------------------------------------------------
module tb_seq_shifter;

`ifdef SEQ_SHIFTER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       st4, st8a, st8b, st5;
    logic [3:0] a4;  logic [1:0] b4;  logic [1:0] op4;
    logic [7:0] a8a; logic [2:0] b8a; logic [1:0] op8a;
    logic [7:0] a8b; logic [2:0] b8b; logic [1:0] op8b;
    logic [4:0] a5;  logic [2:0] b5;  logic [1:0] op5;

    logic [3:0] c4;  logic busy4,  done4,  zero4,  carry4;
    logic [7:0] c8a; logic busy8a, done8a, zero8a, carry8a;
    logic [7:0] c8b; logic busy8b, done8b, zero8b, carry8b;
    logic [4:0] c5;  logic busy5,  done5,  zero5,  carry5;

    seq_shifter #(.N(4), .STEP(1)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .op(op4),
        .c(c4), .busy(busy4), .done(done4), .zero(zero4), .carry(carry4));
    seq_shifter #(.N(8), .STEP(3)) u_d8a (
        .clk(clk), .rst_n(rst_n), .start(st8a), .a(a8a), .b(b8a), .op(op8a),
        .c(c8a), .busy(busy8a), .done(done8a), .zero(zero8a), .carry(carry8a));
    seq_shifter #(.N(8), .STEP(2)) u_d8b (
        .clk(clk), .rst_n(rst_n), .start(st8b), .a(a8b), .b(b8b), .op(op8b),
        .c(c8b), .busy(busy8b), .done(done8b), .zero(zero8b), .carry(carry8b));
    seq_shifter #(.N(5), .STEP(2)) u_d5 (
        .clk(clk), .rst_n(rst_n), .start(st5), .a(a5), .b(b5), .op(op5),
        .c(c5), .busy(busy5), .done(done5), .zero(zero5), .carry(carry5));

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic st, input logic [7:0] av,
                         input logic [7:0] bv, input logic [1:0] ov);
        case (s)
            0:       begin st4  = st; a4  = av[3:0]; b4  = bv[1:0]; op4  = ov; end
            1:       begin st8a = st; a8a = av;      b8a = bv[2:0]; op8a = ov; end
            2:       begin st8b = st; a8b = av;      b8b = bv[2:0]; op8b = ov; end
            default: begin st5  = st; a5  = av[4:0]; b5  = bv[2:0]; op5  = ov; end
        endcase
    endtask

    // {busy, done, zero, carry, c zero-extended to 8 bits}
    function automatic logic [11:0] obs(input int s);
        case (s)
            0:       return {busy4,  done4,  zero4,  carry4,  4'h0, c4};
            1:       return {busy8a, done8a, zero8a, carry8a, c8a};
            2:       return {busy8b, done8b, zero8b, carry8b, c8b};
            default: return {busy5,  done5,  zero5,  carry5,  3'h0, c5};
        endcase
    endfunction

    // Called just after a falling edge. Start is held for `junk` extra
    // edges with scrambled operands, which the busy DUT must ignore.
    task automatic run_op(input string tag, input int s, input logic [7:0] av,
                          input logic [7:0] bv, input logic [1:0] ov,
                          input logic [7:0] exp_c, input logic exp_z,
                          input logic exp_cy, input int exp_lat, input int junk);
        logic [11:0] o;
        logic [7:0]  prev_c;
        int          cnt;
        o      = obs(s);
        prev_c = o[7:0];
        drive(s, 1'b1, av, bv, ov);
        @(posedge clk);
        #1 drive(s, (junk > 0), ~av, ~bv, ~ov);
        cnt = 1;
        @(negedge clk);
        o = obs(s);
        chk({tag, ":busy"}, 32'(o[11]), 32'd1);
        while (!o[10] && cnt < 20) begin
            chk({tag, ":c_hold"}, 32'(o[7:0]), 32'(prev_c));
            @(posedge clk);
            cnt++;
            #1 if (cnt >= junk) drive(s, 1'b0, ~av, ~bv, ~ov);
            @(negedge clk);
            o = obs(s);
        end
        chk({tag, ":latency"}, 32'(cnt), 32'(exp_lat));
        chk({tag, ":c"}, 32'(o[7:0]), 32'(exp_c));
        chk({tag, ":zero"}, 32'(o[9]), 32'(FLAGS ? exp_z : 1'b0));
        chk({tag, ":carry"}, 32'(o[8]), 32'(FLAGS ? exp_cy : 1'b0));
        @(posedge clk);
        #1 drive(s, 1'b0, ~av, ~bv, ~ov);
        @(negedge clk);
        o = obs(s);
        chk({tag, ":done_end"}, 32'(o[10]), 32'd0);
        chk({tag, ":busy_end"}, 32'(o[11]), 32'd0);
        chk({tag, ":c_held"}, 32'(o[7:0]), 32'(exp_c));
    endtask

    initial begin
        logic [11:0] o;
        rst_n = 1'b0;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 8'h00, 8'h00, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 4; s++) chk($sformatf("reset_state_%0d", s), 32'(obs(s)), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //      tag          dut a      b     op     c      z     cy    lat junk
        run_op("srl_b1",     0, 8'h02, 8'd1, 2'b01, 8'h01, 1'b0, 1'b0, 2, 0);
        run_op("srl_b2",     0, 8'h03, 8'd2, 2'b01, 8'h00, 1'b1, 1'b1, 3, 0);
        run_op("b0",         0, 8'h02, 8'd0, 2'b01, 8'h02, 1'b0, 1'b0, 1, 0);
        run_op("sll_b3",     0, 8'h0B, 8'd3, 2'b00, 8'h08, 1'b0, 1'b1, 4, 0);
        run_op("ror_b1",     0, 8'h06, 8'd1, 2'b11, 8'h03, 1'b0, 1'b0, 2, 0);
        run_op("sra_b3",     0, 8'h08, 8'd3, 2'b10, 8'h0F, 1'b0, 1'b0, 4, 0);
        run_op("busy_ign",   0, 8'h08, 8'd3, 2'b01, 8'h01, 1'b0, 1'b0, 4, 2);
        run_op("sra7_st3",   1, 8'h81, 8'd7, 2'b10, 8'hFF, 1'b0, 1'b0, 4, 0);
        run_op("ror1_st2",   2, 8'h01, 8'd1, 2'b11, 8'h80, 1'b0, 1'b1, 2, 0);
        run_op("sll2_st2",   2, 8'hC0, 8'd2, 2'b00, 8'h00, 1'b1, 1'b1, 2, 0);
        run_op("srl7_st2",   2, 8'hF0, 8'd7, 2'b01, 8'h01, 1'b0, 1'b1, 5, 0);
        run_op("n5_srl_b5",  3, 8'h16, 8'd5, 2'b01, 8'h00, 1'b1, 1'b1, 4, 0);
        run_op("n5_sra_b6",  3, 8'h10, 8'd6, 2'b10, 8'h1F, 1'b0, 1'b1, 4, 0);
        run_op("n5_ror_b7",  3, 8'h03, 8'd7, 2'b11, 8'h18, 1'b0, 1'b1, 2, 0);
        run_op("n5_sll_b7",  3, 8'h01, 8'd7, 2'b00, 8'h00, 1'b1, 1'b1, 4, 0);

        // Abort mid-SHIFT: outputs clear at once, no done afterwards.
        drive(0, 1'b1, 8'h01, 8'd3, 2'b00);
        @(posedge clk);
        #1 drive(0, 1'b0, 8'h00, 8'd0, 2'b00);
        @(posedge clk);
        @(negedge clk);
        o = obs(0);
        chk("abort:busy_before", 32'(o[11]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort:outputs", 32'(obs(0)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            o = obs(0);
            chk("abort:no_done", 32'(o[10]), 32'd0);
        end
        run_op("post_rst",   0, 8'h0C, 8'd2, 2'b01, 8'h03, 1'b0, 1'b0, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
